// File: rtl/row_result_collector.sv
// -----------------------------------------------------------------------------
// row_result_collector
//   Sequencer and result collector for the row multiplier. A start pulse
//   launches one pass: for every row a begin_mult pulse is issued with the row
//   index on row_select, the collector waits for a qualified done_row, saturates
//   the returned row sum, stores it, and tracks the running signed maximum.
//   When the last row is captured, result_valid pulses with the winning row
//   index (class_out) and its value (max_value).
//
// Ports
//   clk, n_rst        clock, asynchronous active-low reset
//   start             one-cycle pulse, accepted only when idle
//   done_row          multiplier row-complete pulse
//   row_result        signed 16-bit row sum from the multiplier
//   overflow          row sum left the signed 16-bit range
//   w_result_ena      qualifies done_row as a result write
//   begin_mult        one-cycle pulse starting the current row
//   row_select        current row index (stable ISSUE..CAPTURE)
//   busy              high from accepted start until the pass completes
//   result_valid      one-cycle pulse, class_out/max_value final
//   class_out         index of the row with the largest result
//   max_value         largest saturated row result
//   rd_sel, rd_data   combinational readback of stored row results
// -----------------------------------------------------------------------------
module row_result_collector #(
    parameter int NUM_ROWS = 10
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        start,
    input  logic        done_row,
    input  logic [15:0] row_result,
    input  logic        overflow,
    input  logic        w_result_ena,
    output logic        begin_mult,
    output logic [3:0]  row_select,
    output logic        busy,
    output logic        result_valid,
    output logic [3:0]  class_out,
    output logic [15:0] max_value,
    input  logic [3:0]  rd_sel,
    output logic [15:0] rd_data
);

    localparam logic [3:0]  LAST_ROW  = 4'(NUM_ROWS - 1);
    localparam logic [4:0]  ROW_COUNT = 5'(NUM_ROWS);
    localparam logic [15:0] MOST_NEG  = 16'h8000;
    localparam logic [15:0] MOST_POS  = 16'h7FFF;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT    = 3'd2,
        S_CAPTURE = 3'd3,
        S_FINISH  = 3'd4
    } state_t;

    state_t      state_r;
    state_t      next_state_s;
    logic [3:0]  row_idx_r;
    logic [15:0] cap_r;
    logic [15:0] max_r;
    logic [3:0]  class_r;
    logic        begin_mult_r;
    logic        busy_r;
    logic        result_valid_r;
    logic [15:0] entry_r [16];
    logic        accept_s;
    logic        qual_done_s;
    logic        last_row_s;
    logic        new_max_s;

    // The multiplier flags overflow with the sign bit of the wrapped sum:
    // a set MSB means the true result overflowed positive, a clear MSB negative.
    function automatic logic [15:0] saturate(input logic [15:0] value, input logic ovf);
        logic [15:0] sat_v;
        if (!ovf) begin
            sat_v = value;
        end else if (value[15]) begin
            sat_v = MOST_POS;
        end else begin
            sat_v = MOST_NEG;
        end
        return sat_v;
    endfunction

    assign accept_s    = (state_r == S_IDLE) && start;
    assign qual_done_s = done_row && w_result_ena;
    assign last_row_s  = (row_idx_r == LAST_ROW);
    assign new_max_s   = ($signed(cap_r) > $signed(max_r));

    // Next-state logic of the sequencing FSM.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    next_state_s = S_ISSUE;
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_ISSUE: begin
                next_state_s = S_WAIT;
            end
            S_WAIT: begin
                if (qual_done_s) begin
                    next_state_s = S_CAPTURE;
                end else begin
                    next_state_s = S_WAIT;
                end
            end
            S_CAPTURE: begin
                if (last_row_s) begin
                    next_state_s = S_FINISH;
                end else begin
                    next_state_s = S_ISSUE;
                end
            end
            S_FINISH: begin
                next_state_s = S_IDLE;
            end
            default: begin
                next_state_s = S_IDLE;
            end
        endcase
    end

    // State register and the registered pulse/status outputs, which are
    // decoded from the next state so they align with the state they describe.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r        <= S_IDLE;
            begin_mult_r   <= 1'b0;
            result_valid_r <= 1'b0;
            busy_r         <= 1'b0;
        end else begin
            state_r        <= next_state_s;
            begin_mult_r   <= (next_state_s == S_ISSUE);
            result_valid_r <= (next_state_s == S_FINISH);
            if (accept_s) begin
                busy_r <= 1'b1;
            end else if (state_r == S_FINISH) begin
                busy_r <= 1'b0;
            end
        end
    end

    // Row index, captured result and running maximum.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            row_idx_r <= 4'd0;
            cap_r     <= 16'd0;
            max_r     <= MOST_NEG;
            class_r   <= 4'd0;
        end else begin
            if (accept_s) begin
                row_idx_r <= 4'd0;
                max_r     <= MOST_NEG;
                class_r   <= 4'd0;
            end else if (state_r == S_CAPTURE) begin
                // Strictly-greater compare keeps the lower index on ties.
                if (new_max_s) begin
                    max_r   <= cap_r;
                    class_r <= row_idx_r;
                end
                if (!last_row_s) begin
                    row_idx_r <= row_idx_r + 4'd1;
                end
            end
            if ((state_r == S_WAIT) && qual_done_s) begin
                cap_r <= saturate(row_result, overflow);
            end
        end
    end

    // Result register file; entries persist across passes until rewritten.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < 16; i++) begin
                entry_r[i] <= 16'd0;
            end
        end else begin
            if (state_r == S_CAPTURE) begin
                entry_r[row_idx_r] <= cap_r;
            end
        end
    end

    // Readback mux; rows beyond the configured count read as zero.
    always_comb begin
        rd_data = 16'd0;
        if ({1'b0, rd_sel} < ROW_COUNT) begin
            rd_data = entry_r[rd_sel];
        end else begin
            rd_data = 16'd0;
        end
    end

    assign begin_mult   = begin_mult_r;
    assign row_select   = row_idx_r;
    assign busy         = busy_r;
    assign result_valid = result_valid_r;
    assign class_out    = class_r;
    assign max_value    = max_r;

endmodule
